// File: rtl/pc_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package pc_fetch_pkg;

    localparam int           InstAddrBus = 32;
    localparam int           InstBus     = 32;
    localparam logic [31:0]  ZeroWord    = 32'h0000_0000;
    localparam logic         Stop        = 1'b1;
    localparam logic [6:0]   OpJal       = 7'b1101111;
    localparam logic [6:0]   OpBranch    = 7'b1100011;
    localparam logic [1:0]   BhtInit     = 2'b01;

    // Sign-extended J-type immediate.
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate.
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Saturating 2-bit counter step.
    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pc_fetch_bht.sv
// Bimodal branch history table: combinational read, synchronous saturating update.
module pc_fetch_bht
    import pc_fetch_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [1:0] ctr_r [DEPTH];

    // Read port returns the stored value, so a same-cycle update is not visible yet.
    assign rd_ctr = ctr_r[rd_idx];

    // Counter array update with asynchronous clear to weakly not-taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= BhtInit;
            end
        end else if (upd_valid) begin
            ctr_r[upd_idx] <= bht_next(ctr_r[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, pre-decode of JAL/branches and next-PC selection.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   flush,
    input  logic [InstAddrBus-1:0] flush_pc,
    input  logic                   bht_upd_valid,
    input  logic [InstAddrBus-1:0] bht_upd_pc,
    input  logic                   bht_upd_taken,
    output logic                   imem_ce,
    output logic [InstAddrBus-1:0] imem_addr,
    input  logic [InstBus-1:0]     imem_rdata,
    output logic [InstAddrBus-1:0] if_pc,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_prdt_taken
);

    logic                   ce_r;
    logic [InstAddrBus-1:0] pc_r;
    logic [InstAddrBus-1:0] pc_next_s;
    logic [InstAddrBus-1:0] target_s;
    logic                   taken_s;
    logic [1:0]             bht_ctr_s;
    logic                   unused_s;

    assign unused_s = ^{stall[5:1], bht_upd_pc[InstAddrBus-1:BHT_IDX_W+2], bht_upd_pc[1:0]};

    pc_fetch_bht #(
        .IDX_W     (BHT_IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc_r[BHT_IDX_W+1:2]),
        .rd_ctr    (bht_ctr_s),
        .upd_valid (bht_upd_valid),
        .upd_idx   (bht_upd_pc[BHT_IDX_W+1:2]),
        .upd_taken (bht_upd_taken)
    );

    // Pre-decode the returned word into a prediction and its target.
    always_comb begin
        taken_s  = 1'b0;
        target_s = pc_r + 32'd4;
        case (imem_rdata[6:0])
            OpJal: begin
                taken_s  = 1'b1;
                target_s = pc_r + j_imm(imem_rdata);
            end
            OpBranch: begin
                taken_s  = bht_ctr_s[1];
                target_s = pc_r + b_imm(imem_rdata);
            end
            default: begin
                taken_s  = 1'b0;
                target_s = pc_r + 32'd4;
            end
        endcase
    end

    // Next-PC priority: redirect, then stall, then prediction, then sequential.
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        if (flush) begin
            pc_next_s = flush_pc;
        end else if (stall[0] == Stop) begin
            pc_next_s = pc_r;
        end else if (taken_s) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC and fetch-enable registers; PC stays at RESET_PC until fetch is enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_r <= 1'b0;
            pc_r <= RESET_PC;
        end else begin
            ce_r <= 1'b1;
            if (ce_r) begin
                pc_r <= pc_next_s;
            end else begin
                pc_r <= RESET_PC;
            end
        end
    end

    assign imem_ce       = ce_r;
    assign imem_addr     = pc_r;
    assign if_pc         = pc_r;
    assign if_inst       = ce_r ? imem_rdata : ZeroWord;
    assign if_prdt_taken = ce_r & taken_s;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: directed fetch vectors, monitor compares on the falling edge.
module tb_pc_fetch;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JAL40  = 32'h0400_006F;
    localparam logic [31:0] BEQM16 = 32'hFE00_08E3;
    localparam logic [31:0] JALR0  = 32'h0000_8067;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        tk;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        bht_upd_valid;
    logic [31:0] bht_upd_pc;
    logic        bht_upd_taken;
    logic        imem_ce;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_prdt_taken;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pc_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .bht_upd_valid (bht_upd_valid),
        .bht_upd_pc    (bht_upd_pc),
        .bht_upd_taken (bht_upd_taken),
        .imem_ce       (imem_ce),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .if_inst       (if_inst),
        .if_prdt_taken (if_prdt_taken)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs just after the edge and queue the expected outputs for this cycle.
    task automatic cyc(input logic rstv, input logic st0, input logic fl, input logic [31:0] fpc,
                       input logic [31:0] rd, input logic uv, input logic ut,
                       input logic ece, input logic [31:0] epc, input logic etk, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rstv;
        stall         = {5'b00000, st0};
        flush         = fl;
        flush_pc      = fpc;
        imem_rdata    = rd;
        bht_upd_valid = uv;
        bht_upd_pc    = 32'h0000_0020;
        bht_upd_taken = ut;
        e.ce   = ece;
        e.pc   = epc;
        e.inst = ece ? rd : 32'h0000_0000;
        e.tk   = etk;
        e.nm   = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per falling edge and compare every output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 5;
                if (imem_ce !== e.ce) begin
                    errors++;
                    $display("FAIL %s imem_ce got %0b want %0b", e.nm, imem_ce, e.ce);
                end
                if (if_pc !== e.pc) begin
                    errors++;
                    $display("FAIL %s if_pc got %h want %h", e.nm, if_pc, e.pc);
                end
                if (imem_addr !== e.pc) begin
                    errors++;
                    $display("FAIL %s imem_addr got %h want %h", e.nm, imem_addr, e.pc);
                end
                if (if_inst !== e.inst) begin
                    errors++;
                    $display("FAIL %s if_inst got %h want %h", e.nm, if_inst, e.inst);
                end
                if (if_prdt_taken !== e.tk) begin
                    errors++;
                    $display("FAIL %s if_prdt_taken got %0b want %0b", e.nm, if_prdt_taken, e.tk);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; stall = 6'b000000; flush = 1'b0; flush_pc = 32'h0;
        bht_upd_valid = 1'b0; bht_upd_pc = 32'h0; bht_upd_taken = 1'b0; imem_rdata = NOP;

        //  rst  st fl fpc            rd      uv ut  ce pc             tk
        cyc(1'b0, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "reset0");
        cyc(1'b0, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "reset1");
        cyc(1'b0, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "reset2");
        cyc(1'b1, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "release");
        cyc(1'b1, 0, 0, 32'h0,        NOP,    0, 0,  1, 32'h0,         0, "step0");
        cyc(1'b1, 0, 0, 32'h0,        NOP,    0, 0,  1, 32'h4,         0, "step4");
        cyc(1'b1, 0, 0, 32'h0,        NOP,    0, 0,  1, 32'h8,         0, "step8");
        cyc(1'b1, 0, 1, 32'h10,       NOP,    0, 0,  1, 32'hC,         0, "flush_to_10");
        cyc(1'b1, 0, 0, 32'h0,        JAL40,  0, 0,  1, 32'h10,        1, "jal_pred");
        cyc(1'b1, 0, 1, 32'h20,       NOP,    0, 0,  1, 32'h50,        0, "jal_target");
        // BEQ at 0x20: not-taken at init; same-cycle update must not affect this read
        cyc(1'b1, 0, 0, 32'h0,        BEQM16, 1, 1,  1, 32'h20,        0, "beq_init_nt");
        cyc(1'b1, 0, 1, 32'h20,       NOP,    1, 1,  1, 32'h24,        0, "beq_fallthru");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 1,  1, 32'h20,        1, "beq_trained");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 0,  1, 32'h20,        1, "bht_sat_hi");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 0,  1, 32'h20,        1, "bht_2");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 0,  1, 32'h20,        0, "bht_1");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 0,  1, 32'h20,        0, "bht_0");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 1,  1, 32'h20,        0, "bht_sat_lo");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 1,  1, 32'h20,        0, "bht_back_1");
        cyc(1'b1, 0, 0, 32'h0,        BEQM16, 0, 0,  1, 32'h20,        1, "bht_back_2");
        cyc(1'b1, 1, 0, 32'h0,        NOP,    0, 0,  1, 32'h10,        0, "beq_target");
        cyc(1'b1, 1, 0, 32'h0,        NOP,    0, 0,  1, 32'h10,        0, "stall_hold1");
        cyc(1'b1, 1, 1, 32'h200,      NOP,    0, 0,  1, 32'h10,        0, "stall_hold2");
        cyc(1'b1, 0, 1, 32'hFFFF_FFFC, NOP,   0, 0,  1, 32'h200,       0, "flush_wins");
        cyc(1'b1, 0, 0, 32'h0,        JALR0,  0, 0,  1, 32'hFFFF_FFFC, 0, "jalr_nt");
        cyc(1'b1, 0, 1, 32'h80,       NOP,    0, 0,  1, 32'h0,         0, "wrap");
        cyc(1'b1, 1, 0, 32'h0,        NOP,    0, 0,  1, 32'h80,        0, "at_80");
        cyc(1'b0, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "async_rst");
        cyc(1'b1, 0, 0, 32'h0,        NOP,    0, 0,  0, 32'h0,         0, "rerelease");
        cyc(1'b1, 0, 1, 32'h20,       NOP,    0, 0,  1, 32'h0,         0, "restart");
        cyc(1'b1, 1, 0, 32'h0,        BEQM16, 1, 1,  1, 32'h20,        0, "bht_reinit");
        cyc(1'b1, 0, 0, 32'h0,        BEQM16, 0, 0,  1, 32'h20,        1, "bht_reinit_01");

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
